sram_ret_wrapper: RTL and testbench

SRAM_RET_WRAPPER -- requirements
Module: sram_ret_wrapper

---
 rtl/sram_ret_pkg.sv | 12 +
 rtl/sram_ret_array.sv | 49 ++++
 rtl/sram_ret_wrapper.sv | 139 +++++++++++++
 tb/tb_sram_ret_wrapper.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ret_pkg.sv
// Shared definitions for the retention-capable SRAM wrapper.
// Contents: ret_state_e, the power-state encoding used by sram_ret_wrapper.
package sram_ret_pkg;

    typedef enum logic [1:0] {
        ACTIVE    = 2'd0,
        ENTER_RET = 2'd1,
        RETENTION = 2'd2,
        WAKEUP    = 2'd3
    } ret_state_e;

endpackage

// File: rtl/sram_ret_array.sv
// Behavioural single-port storage array: byte-enable write, registered read.
// Kept free of reset and control logic so a technology macro can replace it.
// Ports:
//   clk_i    clock
//   we_i     write strobe (already qualified by the grant)
//   re_i     read strobe (already qualified by the grant)
//   addr_i   word address; addresses >= NumWords are ignored on write, read as 0
//   wdata_i  write data
//   be_i     byte enables
//   rdata_o  read data, valid the cycle after re_i, held until the next re_i
module sram_ret_array #(
    parameter int NumWords  = 1024,
    parameter int DataWidth = 32,
    parameter int AddrWidth = 10
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [AddrWidth-1:0]     addr_i,
    input  logic [DataWidth-1:0]     wdata_i,
    input  logic [DataWidth/8-1:0]   be_i,
    output logic [DataWidth-1:0]     rdata_o
);

    localparam int BeWidth = DataWidth / 8;

    logic [DataWidth-1:0] mem_q [NumWords];
    logic [DataWidth-1:0] rdata_q;
    logic                 in_range;

    // One extra bit so NumWords == 2**AddrWidth still compares correctly.
    assign in_range = {1'b0, addr_i} < (AddrWidth + 1)'(NumWords);

    always_ff @(posedge clk_i) begin
        if (we_i && in_range) begin
            for (int b = 0; b < BeWidth; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= in_range ? mem_q[addr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_ret_wrapper.sv
// SRAM wrapper with retention sequencing and an optional read output register.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_i / gnt_o         access request / accepted this cycle (only in ACTIVE)
//   we_i, addr_i          1 = write, 0 = read; word address
//   wdata_i, be_i         write data and byte enables
//   set_retentive_i       request retention; deassert to wake up
//   rdata_o / rvalid_o    read data / one-cycle valid, 1+OutputReg cycles after grant
//   retentive_o           high while in RETENTION
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ACTIVE    | accesses granted; leaves when retention requested, no read pending
// ENTER_RET | one-cycle handoff into retention, no grants
// RETENTION | array held, retentive_o high, no grants
// WAKEUP    | counts WakeupCycles cycles before returning to ACTIVE
module sram_ret_wrapper
    import sram_ret_pkg::*;
#(
    parameter int NumWords     = 1024,
    parameter int DataWidth    = 32,
    parameter int WakeupCycles = 4,
    parameter int OutputReg    = 0,
    localparam int AddrWidth   = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int BeWidth     = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeWidth-1:0]   be_i,
    input  logic                 set_retentive_i,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 rvalid_o,
    output logic                 retentive_o
);

    localparam int                CntWidth = $clog2(WakeupCycles + 1);
    localparam logic [CntWidth-1:0] CntLoad = CntWidth'(WakeupCycles - 1);

    ret_state_e           state_q;
    logic [CntWidth-1:0]  cnt_q;
    logic                 retentive_q;
    logic                 rv1_q;
    logic                 rv2_q;
    logic                 seen_q;
    logic [DataWidth-1:0] rdata_q;
    logic [DataWidth-1:0] arr_rdata;
    logic                 wr_gnt;
    logic                 rd_gnt;
    logic                 rd_pending;

    assign gnt_o  = req_i && (state_q == ACTIVE);
    assign wr_gnt = gnt_o && we_i;
    assign rd_gnt = gnt_o && !we_i;

    // A read is pending until its rvalid_o has been driven. With the output
    // register, the first pipeline stage is still ahead of rvalid_o.
    assign rd_pending = rd_gnt || ((OutputReg != 0) && rv1_q);

    sram_ret_array #(
        .NumWords  (NumWords),
        .DataWidth (DataWidth),
        .AddrWidth (AddrWidth)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (wr_gnt),
        .re_i    (rd_gnt),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .be_i    (be_i),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ACTIVE;
            cnt_q       <= '0;
            retentive_q <= 1'b0;
        end else begin
            case (state_q)
                ACTIVE: begin
                    if (set_retentive_i && !rd_pending) begin
                        state_q <= ENTER_RET;
                    end
                end
                ENTER_RET: begin
                    state_q     <= RETENTION;
                    retentive_q <= 1'b1;
                end
                RETENTION: begin
                    if (!set_retentive_i) begin
                        state_q     <= WAKEUP;
                        retentive_q <= 1'b0;
                        cnt_q       <= CntLoad;
                    end
                end
                WAKEUP: begin
                    if (cnt_q == '0) begin
                        state_q <= ACTIVE;
                    end else begin
                        cnt_q <= cnt_q - CntWidth'(1);
                    end
                end
                default: begin
                    state_q <= ACTIVE;
                end
            endcase
        end
    end

    // seen_q masks the unreset array read register until the first read after
    // reset, so rdata_o reads as zero out of reset without OutputReg.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rv1_q   <= 1'b0;
            rv2_q   <= 1'b0;
            seen_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            rv1_q <= rd_gnt;
            rv2_q <= rv1_q;
            if (rd_gnt) begin
                seen_q <= 1'b1;
            end
            if (rv1_q) begin
                rdata_q <= arr_rdata;
            end
        end
    end

    assign rvalid_o    = (OutputReg != 0) ? rv2_q : rv1_q;
    assign rdata_o     = (OutputReg != 0) ? rdata_q : (seen_q ? arr_rdata : '0);
    assign retentive_o = retentive_q;

endmodule

// File: tb/tb_sram_ret_wrapper.sv
// Directed bench for sram_ret_wrapper.
// dut0: NumWords=1000, OutputReg=0, WakeupCycles=4 (vectors, retention, reset).
// dut1: NumWords=1024, OutputReg=1 (read latency, reset mid-read).
module tb_sram_ret_wrapper;

    logic        clk;
    logic        rst0_n, rst1_n;

    logic        req0, we0, setret0, gnt0, rvalid0, ret0;
    logic [9:0]  addr0;
    logic [31:0] wdata0, rdata0;
    logic [3:0]  be0;

    logic        req1, we1, setret1, gnt1, rvalid1, ret1;
    logic [9:0]  addr1;
    logic [31:0] wdata1, rdata1;
    logic [3:0]  be1;

    int n_checks = 0;
    int n_errors = 0;

    sram_ret_wrapper #(.NumWords(1000), .DataWidth(32), .WakeupCycles(4), .OutputReg(0)) dut0 (
        .clk_i(clk), .rst_ni(rst0_n), .req_i(req0), .gnt_o(gnt0), .we_i(we0),
        .addr_i(addr0), .wdata_i(wdata0), .be_i(be0), .set_retentive_i(setret0),
        .rdata_o(rdata0), .rvalid_o(rvalid0), .retentive_o(ret0)
    );

    sram_ret_wrapper #(.NumWords(1024), .DataWidth(32), .WakeupCycles(4), .OutputReg(1)) dut1 (
        .clk_i(clk), .rst_ni(rst1_n), .req_i(req1), .gnt_o(gnt1), .we_i(we1),
        .addr_i(addr1), .wdata_i(wdata1), .be_i(be1), .set_retentive_i(setret1),
        .rdata_o(rdata1), .rvalid_o(rvalid1), .retentive_o(ret1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_rv;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];
    logic [31:0] d1_data [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 10'd5,    32'hAABBCCDD, 4'hF, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 10'd5,    32'h11223344, 4'h5, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 10'd5,    32'h0,        4'h0, 1'b1, 32'hAA22CC44};
        vecs[3]  = '{1'b1, 10'd6,    32'h12345678, 4'h0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 10'd6,    32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 10'd6,    32'h00000000, 4'h0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 10'd6,    32'h0,        4'h0, 1'b1, 32'hCAFEF00D};
        vecs[7]  = '{1'b1, 10'd10,   32'h0A0A0A0A, 4'hF, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 10'd498,  32'h1F1F1F1F, 4'hF, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 10'd1010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 10'd1010, 32'h0,        4'h0, 1'b1, 32'h00000000};
        vecs[11] = '{1'b0, 10'd10,   32'h0,        4'h0, 1'b1, 32'h0A0A0A0A};
        vecs[12] = '{1'b0, 10'd498,  32'h0,        4'h0, 1'b1, 32'h1F1F1F1F};
        d1_data[0] = 32'h0000_1111;
        d1_data[1] = 32'h2222_0000;
        d1_data[2] = 32'h3333_3333;

        // Reset state; req0 held as a no-op write so gnt follows req in ACTIVE.
        rst0_n = 1'b0; rst1_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = '0; wdata0 = '0; be0 = '0; setret0 = 1'b0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; be1 = '0; setret1 = 1'b0;
        #2;
        chk("rst_gnt", gnt0, 1'b1);
        chk("rst_rvalid", rvalid0, 1'b0);
        chk("rst_rdata", rdata0, 32'h0);
        chk("rst_retentive", ret0, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_rdata1", rdata1, 32'h0);
        step();
        step();
        rst0_n = 1'b1; rst1_n = 1'b1;
        req0 = 1'b0;

        // Table-driven accesses on dut0, back to back.
        for (int i = 0; i < NV; i++) begin
            req0 = 1'b1; we0 = vecs[i].we; addr0 = vecs[i].addr;
            wdata0 = vecs[i].wdata; be0 = vecs[i].be;
            #1;
            chk($sformatf("vec%0d_gnt", i), gnt0, 1'b1);
            step();
            chk($sformatf("vec%0d_rvalid", i), rvalid0, vecs[i].exp_rv);
            if (vecs[i].exp_rv) chk($sformatf("vec%0d_rdata", i), rdata0, vecs[i].exp_rdata);
        end
        req0 = 1'b0;
        step();
        chk("hold_rvalid", rvalid0, 1'b0);
        chk("hold_rdata", rdata0, 32'h1F1F1F1F);

        // Retention cycle with a held no-op write request.
        setret0 = 1'b1; req0 = 1'b1; we0 = 1'b1; be0 = 4'h0; addr0 = 10'd5;
        #1;
        chk("ret_gnt_coincide", gnt0, 1'b1);
        step();
        chk("ret_enter_gnt", gnt0, 1'b0);
        chk("ret_enter_retentive", ret0, 1'b0);
        step();
        chk("ret_retentive", ret0, 1'b1);
        chk("ret_gnt", gnt0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("ret_hold_retentive", ret0, 1'b1);
            chk("ret_hold_gnt", gnt0, 1'b0);
        end
        setret0 = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wake%0d_gnt", k), gnt0, 1'b0);
            chk($sformatf("wake%0d_retentive", k), ret0, 1'b0);
            step();
        end
        chk("wake_done_gnt", gnt0, 1'b1);
        we0 = 1'b0; addr0 = 10'd5;
        step();
        chk("post_ret_rvalid5", rvalid0, 1'b1);
        chk("post_ret_rdata5", rdata0, 32'hAA22CC44);
        addr0 = 10'd6;
        step();
        chk("post_ret_rvalid6", rvalid0, 1'b1);
        chk("post_ret_rdata6", rdata0, 32'hCAFEF00D);
        req0 = 1'b0;

        // Retention requested in the same cycle a read is granted.
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'd6; setret0 = 1'b1;
        #1;
        chk("defer_gnt", gnt0, 1'b1);
        step();
        chk("defer_rvalid", rvalid0, 1'b1);
        chk("defer_rdata", rdata0, 32'hCAFEF00D);
        chk("defer_retentive", ret0, 1'b0);
        we0 = 1'b1; be0 = 4'h0;
        #1;
        chk("defer_still_active", gnt0, 1'b1);
        step();
        chk("defer_enter_gnt", gnt0, 1'b0);
        chk("defer_enter_rvalid", rvalid0, 1'b0);
        step();
        chk("defer_retentive_on", ret0, 1'b1);

        // Reset in the middle of WAKEUP.
        setret0 = 1'b0;
        step();
        step();
        chk("midwake_gnt", gnt0, 1'b0);
        #2;
        rst0_n = 1'b0;
        #1;
        chk("midwake_rst_gnt", gnt0, 1'b1);
        chk("midwake_rst_rvalid", rvalid0, 1'b0);
        chk("midwake_rst_retentive", ret0, 1'b0);
        chk("midwake_rst_rdata", rdata0, 32'h0);
        step();
        rst0_n = 1'b1;
        #1;
        chk("midwake_rel_gnt", gnt0, 1'b1);
        step();
        chk("midwake_rel_rvalid", rvalid0, 1'b0);
        chk("midwake_rel_gnt2", gnt0, 1'b1);
        req0 = 1'b0;

        // dut1: preload three words, then back-to-back reads with latency 2.
        for (int i = 0; i < 3; i++) begin
            req1 = 1'b1; we1 = 1'b1; addr1 = 10'(i); wdata1 = d1_data[i]; be1 = 4'hF;
            step();
            chk("d1_write_rvalid", rvalid1, 1'b0);
        end
        we1 = 1'b0; addr1 = 10'd0;
        step();
        chk("lat_r0_e1_rvalid", rvalid1, 1'b0);
        addr1 = 10'd1;
        step();
        chk("lat_r0_rvalid", rvalid1, 1'b1);
        chk("lat_r0_rdata", rdata1, d1_data[0]);
        addr1 = 10'd2;
        step();
        chk("lat_r1_rvalid", rvalid1, 1'b1);
        chk("lat_r1_rdata", rdata1, d1_data[1]);
        req1 = 1'b0;
        step();
        chk("lat_r2_rvalid", rvalid1, 1'b1);
        chk("lat_r2_rdata", rdata1, d1_data[2]);
        step();
        chk("lat_idle_rvalid", rvalid1, 1'b0);
        chk("lat_hold_rdata", rdata1, d1_data[2]);

        // dut1: reset while a read is in the pipeline.
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'd1;
        step();
        req1 = 1'b0;
        chk("midread_rvalid_pre", rvalid1, 1'b0);
        #2;
        rst1_n = 1'b0;
        #2;
        rst1_n = 1'b1;
        step();
        chk("midread_rvalid_a", rvalid1, 1'b0);
        chk("midread_rdata", rdata1, 32'h0);
        step();
        chk("midread_rvalid_b", rvalid1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
